fifo_word_reader: RTL and testbench

FIFO_WORD_READER -- requirements
Module: fifo_word_reader

---
 rtl/fifo_word_reader_pkg.sv | 9 +
 rtl/fifo_word_reader_timer.sv | 20 ++
 rtl/fifo_word_reader.sv | 83 ++++++++
 tb/tb_fifo_word_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_reader_pkg.sv
// fifo_word_reader_pkg: state encoding, default parameters and word width shared by the FIFO word reader
package fifo_word_reader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_REQ_HI, S_WAIT_HI, S_REQ_LO, S_WAIT_LO, S_OUTPUT, S_DONE, S_ERR
  } state_t;
  localparam int DEF_WORDS_PER_FRAME = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int WORD_W = 16;
endpackage

// File: rtl/fifo_word_reader_timer.sv
// read_timeout_timer: counts wait cycles without read data and flags the cycle that reaches the limit
module read_timeout_timer
  import fifo_word_reader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (clear) r_count <= '0;
    else if (enable) r_count <= r_count + 1'b1;
  end
  // high on the cycle whose increment brings the count to the limit
  assign expired = enable && (r_count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/fifo_word_reader.sv
// fifo_word_reader: reads byte pairs from a FIFO and hands out WORDS_PER_FRAME 16-bit words per start
module fifo_word_reader
  import fifo_word_reader_pkg::*;
#(
  parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic              read_en,
  input  logic [7:0]        data_in,
  input  logic              empty,
  input  logic              valid,
  input  logic              underflow,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready
);
  localparam int IW = $clog2(WORDS_PER_FRAME + 1);
  state_t r_state, w_next;
  logic [IW-1:0] r_idx, w_idx_inc;
  logic w_expired, w_in_wait, w_in_req, w_accept;
  logic r_done, r_error, r_busy, r_read_en, r_word_valid;
  logic [WORD_W-1:0] r_word_out;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_in_wait = r_state == S_WAIT_HI || r_state == S_WAIT_LO;
  assign w_in_req = r_state == S_REQ_HI || r_state == S_REQ_LO;
  assign w_accept = r_state == S_IDLE && start;
  read_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .clear(reset || w_in_req),
    .enable(w_in_wait && !valid),
    .expired(w_expired)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = start ? S_REQ_HI : S_IDLE;
      S_REQ_HI:  w_next = empty ? S_REQ_HI : S_WAIT_HI;
      S_WAIT_HI: w_next = valid ? S_REQ_LO : w_expired ? S_ERR : S_WAIT_HI;
      S_REQ_LO:  w_next = empty ? S_REQ_LO : S_WAIT_LO;
      S_WAIT_LO: w_next = valid ? S_OUTPUT : w_expired ? S_ERR : S_WAIT_LO;
      S_OUTPUT:  w_next = !word_ready ? S_OUTPUT :
                          (w_idx_inc == IW'(WORDS_PER_FRAME)) ? S_DONE : S_REQ_HI;
      default:   w_next = S_IDLE;
    endcase
    // underflow overrides everything once a frame is running; S_ERR is already on its way out
    if (underflow && r_state != S_IDLE && r_state != S_ERR) w_next = S_ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_word_out   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
      r_read_en    <= 1'b0;
      r_word_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_done       <= w_next == S_DONE || w_next == S_ERR;
      r_busy       <= w_next != S_IDLE;
      r_read_en    <= w_in_req && (w_next == S_WAIT_HI || w_next == S_WAIT_LO);
      r_word_valid <= w_next == S_OUTPUT;
      r_error      <= w_accept ? 1'b0 : (w_next == S_ERR) ? 1'b1 : r_error;
      if (w_accept) r_idx <= '0;
      else if (r_state == S_OUTPUT && (w_next == S_DONE || w_next == S_REQ_HI)) r_idx <= w_idx_inc;
      if (r_state == S_WAIT_HI && w_next == S_REQ_LO) r_word_out[WORD_W-1:8] <= data_in;
      if (r_state == S_WAIT_LO && w_next == S_OUTPUT) r_word_out[7:0] <= data_in;
    end
  end
  assign done = r_done;
  assign error = r_error;
  assign busy = r_busy;
  assign read_en = r_read_en;
  assign word_out = r_word_out;
  assign word_valid = r_word_valid;
endmodule

// File: tb/tb_fifo_word_reader.sv
// tb_fifo_word_reader: byte-FIFO model plus word scoreboard around fifo_word_reader
module tb_fifo_word_reader;
  logic clk = 0, reset = 1, start = 0, valid = 0, empty = 1, underflow = 0, word_ready = 0;
  logic [7:0] data_in = 0;
  logic done, error, busy, read_en, word_valid;
  logic [15:0] word_out;
  logic force_empty = 0, withhold = 0, pending = 0, wv_seen = 0;
  logic prev_wv = 0, prev_rdy = 0;
  logic [15:0] prev_word = 0;
  int n_tests = 0, n_fail = 0, n_done = 0, n0 = 0, k = 0;
  logic [7:0] fifo_q[$];
  logic [15:0] exp_q[$];

  fifo_word_reader #(.WORDS_PER_FRAME(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .error(error), .busy(busy),
    .read_en(read_en), .data_in(data_in), .empty(empty), .valid(valid),
    .underflow(underflow), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic load(input logic push_exp);
    logic [63:0] f;
    f = 64'hAABBCCDD11223344;
    for (int i = 0; i < 8; i++) fifo_q.push_back(f[63-8*i -: 8]);
    if (push_exp) for (int i = 0; i < 4; i++) exp_q.push_back(f[63-16*i -: 16]);
  endtask

  // sel: 0 = done, 1 = word_valid, 2 = read_en
  task automatic wait_sig(input string tag, input int sel, input int max);
    logic hit;
    hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      tick();
      hit = sel == 0 ? done : sel == 1 ? word_valid : read_en;
    end
    check(tag, 32'(hit), 1);
  endtask

  // FIFO: read data shows up one cycle after the read request is seen
  initial forever begin
    @(negedge clk);
    valid = 0;
    if (pending) begin
      if (!withhold && fifo_q.size() > 0) begin
        data_in = fifo_q.pop_front();
        valid = 1;
      end
      pending = 0;
    end
    if (read_en === 1'b1) pending = 1;
    empty = force_empty || fifo_q.size() == 0;
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (done === 1'b1) n_done++;
    if (word_valid === 1'b1) wv_seen = 1;
    if (word_valid === 1'b1 && prev_wv && !prev_rdy) check("word_hold", 32'(word_out), 32'(prev_word));
    if (word_valid === 1'b1 && word_ready) begin
      if (exp_q.size() == 0) check("extra_word", 0, 1);
      else check("word", 32'(word_out), 32'(exp_q.pop_front()));
    end
    prev_wv = word_valid === 1'b1;
    prev_rdy = word_ready;
    prev_word = word_out;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_outs", 32'({done, error, busy, read_en, word_valid, word_out}), 0);
    reset = 0;
    // full frame, ready always high; start on the done cycle is ignored
    load(1);
    word_ready = 1;
    n0 = n_done;
    pulse_start();
    check("s1_busy", 32'(busy), 1);
    wait_sig("s1_done", 0, 100);
    check("s1_err", 32'(error), 0);
    start = 1;
    tick();
    start = 0;
    check("s1_start_on_done", 32'(busy), 0);
    check("s1_words_left", 32'(exp_q.size()), 0);
    check("s1_done_cnt", 32'(n_done - n0), 1);
    // backpressure on the first word, start mid-frame ignored
    load(1);
    word_ready = 0;
    pulse_start();
    wait_sig("s2_wv", 1, 100);
    for (int i = 0; i < 10; i++) begin
      start = i == 3;
      check("s2_wv_hold", 32'(word_valid), 1);
      check("s2_word", 32'(word_out), 32'hAABB);
      check("s2_no_rd", 32'(read_en), 0);
      tick();
    end
    start = 0;
    check("s2_fifo_left", 32'(fifo_q.size()), 6);
    word_ready = 1;
    wait_sig("s2_done", 0, 100);
    check("s2_err", 32'(error), 0);
    tick();
    tick();
    check("s2_idle", 32'(busy), 0);
    check("s2_words_left", 32'(exp_q.size()), 0);
    // FIFO empty after the first byte
    load(1);
    pulse_start();
    wait_sig("s3_rd1", 2, 20);
    force_empty = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s3_rd_empty", 32'(read_en), 0);
    end
    force_empty = 0;
    wait_sig("s3_done", 0, 100);
    check("s3_err", 32'(error), 0);
    tick();
    check("s3_words_left", 32'(exp_q.size()), 0);
    // read data withheld: timeout
    load(0);
    withhold = 1;
    pulse_start();
    wait_sig("s4_rd", 2, 20);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("s4_timeout_lat", 32'(k), 8);
    check("s4_err_done", 32'({error, done}), 3);
    tick();
    check("s4_idle", 32'({busy, done, error}), 1);
    withhold = 0;
    fifo_q.delete();
    tick();
    // underflow while waiting for the low byte
    load(0);
    wv_seen = 0;
    pulse_start();
    check("s5_err_clr", 32'(error), 0);
    wait_sig("s5_rd_hi", 2, 20);
    wait_sig("s5_rd_lo", 2, 20);
    underflow = 1;
    tick();
    underflow = 0;
    check("s5_err", 32'({error, done, word_valid}), 6);
    tick();
    tick();
    check("s5_no_wv", 32'(wv_seen), 0);
    check("s5_word", 32'(word_out), 32'hAA44);
    check("s5_idle", 32'(busy), 0);
    fifo_q.delete();
    // reset while presenting a word, then a clean frame
    load(1);
    word_ready = 0;
    pulse_start();
    wait_sig("s6_wv", 1, 100);
    reset = 1;
    tick();
    reset = 0;
    check("s6_rst", 32'({done, error, busy, read_en, word_valid, word_out}), 0);
    exp_q.delete();
    fifo_q.delete();
    tick();
    load(1);
    word_ready = 1;
    n0 = n_done;
    pulse_start();
    wait_sig("s6_done", 0, 100);
    check("s6_err", 32'(error), 0);
    tick();
    check("s6_words_left", 32'(exp_q.size()), 0);
    check("s6_done_cnt", 32'(n_done - n0), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
